// File: rtl/fetch_unit.sv
// Instruction fetch: issues word-aligned reads, queues {pc, word} for decode; response-to-instr_valid is one cycle.
// Requests stall when queue plus in-flight reads would exceed DEPTH; redirects flush the queue and drop stale responses.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic {BOOT, RUN} state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } entry_t;

  state_e         state_q, state_d;
  logic [31:0]    fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]  q_count_q, q_count_d;
  logic [CW-1:0]  outstanding_q, outstanding_d;
  logic [CW-1:0]  drop_cnt_q, drop_cnt_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  entry_t         mem_q [DEPTH];
  entry_t         mem_d [DEPTH];

  logic           run;
  logic [CW:0]    inflight;
  logic           req_fire;
  logic           rsp_fire;
  logic           push;
  logic           pop;
  logic [31:0]    rsp_pc;
  logic           unused_redirect_bits;

  assign unused_redirect_bits = ^redirect_pc[1:0];

  always_comb begin
    run      = (state_q == RUN);
    inflight = {1'b0, q_count_q} + {1'b0, outstanding_q};

    imem_req_valid = run && !redirect_valid && (inflight < (CW+1)'(DEPTH));
    imem_req_addr  = fetch_pc_q;
    instr_valid    = run && (q_count_q != '0);
    instr          = instr_valid ? mem_q[rd_ptr_q].word : 32'h0;
    instr_pc       = instr_valid ? mem_q[rd_ptr_q].pc   : 32'h0;

    req_fire = imem_req_valid && imem_req_ready;
    rsp_fire = run && imem_rsp_valid;
    push     = rsp_fire && !redirect_valid && (drop_cnt_q == '0);
    pop      = instr_valid && instr_ready && !redirect_valid;
    // With no drops pending, every in-flight read is on the current path and
    // contiguous up to fetch_pc, so the oldest one sits outstanding words back.
    rsp_pc   = fetch_pc_q - {{(30-CW){1'b0}}, outstanding_q, 2'b00};
  end

  always_comb begin
    state_d       = RUN;
    fetch_pc_d    = fetch_pc_q;
    q_count_d     = q_count_q;
    outstanding_d = outstanding_q;
    drop_cnt_d    = drop_cnt_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    mem_d         = mem_q;

    if (run) begin
      if (redirect_valid) begin
        fetch_pc_d    = {redirect_pc[31:2], 2'b00};
        q_count_d     = '0;
        rd_ptr_d      = '0;
        wr_ptr_d      = '0;
        outstanding_d = outstanding_q - CW'(rsp_fire);
        drop_cnt_d    = outstanding_q - CW'(rsp_fire);
      end else begin
        if (req_fire) begin
          fetch_pc_d = fetch_pc_q + 32'd4;
        end
        outstanding_d = outstanding_q + CW'(req_fire) - CW'(rsp_fire);
        if (rsp_fire && (drop_cnt_q != '0)) begin
          drop_cnt_d = drop_cnt_q - 1'b1;
        end
        if (push) begin
          mem_d[wr_ptr_q] = '{pc: rsp_pc, word: imem_rsp_data};
          wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
          rd_ptr_d = rd_ptr_q + 1'b1;
        end
        q_count_d = q_count_q + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= BOOT;
      fetch_pc_q    <= {RESET_PC[31:2], 2'b00};
      q_count_q     <= '0;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      q_count_q     <= q_count_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      mem_q         <= mem_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a behavioural in-order instruction memory of programmable latency.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data  = 32'h0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int n_chk  = 0;
  int n_fail = 0;
  int lat    = 1;
  int acc_cnt = 0;
  int edge_no = 0;
  int acc0;
  logic [31:0] pend_addr [$];
  int          pend_due  [$];

  fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  always #5 clk = ~clk;

  // Memory: samples the handshake at the edge, returns ~addr in order, lat edges later.
  always @(posedge clk) begin
    if (reset) begin
      pend_addr.delete();
      pend_due.delete();
    end else begin
      if (imem_rsp_valid && pend_addr.size() > 0) begin
        void'(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end
      if (imem_req_valid && imem_req_ready) begin
        pend_addr.push_back(imem_req_addr);
        pend_due.push_back(edge_no + lat);
        acc_cnt++;
      end
    end
    edge_no++;
    #1;
    if (pend_addr.size() > 0 && pend_due[0] <= edge_no) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = ~pend_addr[0];
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    nxt();
    nxt();
    #1;
    chk("rst_req_valid",   imem_req_valid, 32'd0);
    chk("rst_instr_valid", instr_valid,    32'd0);
    chk("rst_instr",       instr,          32'd0);
    chk("rst_instr_pc",    instr_pc,       32'd0);
    reset = 1'b0;
    #1;
    chk("boot_req_valid",   imem_req_valid, 32'd0);
    chk("boot_instr_valid", instr_valid,    32'd0);
    nxt();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the end (observed timeout, expected finish)");
    $fatal(1, "watchdog");
  end

  initial begin
    reset          = 1'b1;
    imem_req_ready = 1'b1;
    instr_ready    = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;

    // Streaming, latency 1, decode always ready
    lat = 1;
    do_reset();
    #1;
    chk("s1_c0_req_valid", imem_req_valid, 32'd1);
    chk("s1_c0_addr",      imem_req_addr,  32'h0);
    nxt(); #1;
    chk("s1_c1_addr",        imem_req_addr, 32'h4);
    chk("s1_c1_instr_valid", instr_valid,   32'd0);
    nxt(); #1;
    chk("s1_c2_instr_valid", instr_valid,   32'd1);
    chk("s1_c2_instr_pc",    instr_pc,      32'h0);
    chk("s1_c2_instr",       instr,         32'hFFFF_FFFF);
    chk("s1_c2_addr",        imem_req_addr, 32'h8);
    nxt(); #1;
    chk("s1_c3_instr_pc", instr_pc, 32'h4);
    nxt(); #1;
    chk("s1_c4_instr_pc", instr_pc,      32'h8);
    chk("s1_c4_instr",    instr,         32'hFFFF_FFF7);
    chk("s1_c4_addr",     imem_req_addr, 32'h10);

    // Decode stalled: queue fills with exactly DEPTH requests
    instr_ready = 1'b0;
    do_reset();
    acc0 = acc_cnt;
    repeat (5) nxt();
    #1;
    chk("s2_full_req_valid",   imem_req_valid,  32'd0);
    chk("s2_full_instr_valid", instr_valid,     32'd1);
    chk("s2_full_head_pc",     instr_pc,        32'h0);
    chk("s2_full_req_count",   acc_cnt - acc0,  32'd4);
    nxt();
    instr_ready = 1'b1;
    #1;
    chk("s2_pop_req_valid", imem_req_valid, 32'd0);
    nxt();
    instr_ready = 1'b0;
    #1;
    chk("s2_after_pop_pc",        instr_pc,       32'h4);
    chk("s2_after_pop_req_valid", imem_req_valid, 32'd1);
    chk("s2_after_pop_addr",      imem_req_addr,  32'h10);
    nxt(); #1;
    chk("s2_refill_req_valid", imem_req_valid, 32'd0);
    chk("s2_refill_count",     acc_cnt - acc0, 32'd5);

    // Asynchronous reset with queue occupied and a read in flight
    reset = 1'b1;
    #1;
    chk("s2_async_req_valid",   imem_req_valid, 32'd0);
    chk("s2_async_instr_valid", instr_valid,    32'd0);
    chk("s2_async_instr",       instr,          32'd0);
    chk("s2_async_instr_pc",    instr_pc,       32'd0);

    // Redirect with two reads outstanding at latency 3
    lat = 3;
    instr_ready = 1'b1;
    do_reset();
    #1;
    chk("s3_first_addr", imem_req_addr, 32'h0);
    nxt(); #1;
    chk("s3_c1_addr", imem_req_addr, 32'h4);
    nxt();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    #1;
    chk("s3_redir_req_valid", imem_req_valid, 32'd0);
    nxt();
    redirect_valid = 1'b0;
    #1;
    chk("s3_c3_req_valid",   imem_req_valid,  32'd1);
    chk("s3_c3_addr",        imem_req_addr,   32'h100);
    chk("s3_c3_drop_cnt",    dut.drop_cnt_q,  32'd2);
    chk("s3_c3_instr_valid", instr_valid,     32'd0);
    nxt(); #1;
    chk("s3_c4_instr_valid", instr_valid, 32'd0);
    nxt(); #1;
    chk("s3_c5_instr_valid", instr_valid,    32'd0);
    chk("s3_c5_drop_cnt",    dut.drop_cnt_q, 32'd0);
    nxt(); #1;
    chk("s3_c6_instr_valid", instr_valid, 32'd0);
    nxt(); #1;
    chk("s3_c7_instr_valid", instr_valid, 32'd1);
    chk("s3_c7_instr_pc",    instr_pc,    32'h100);
    chk("s3_c7_instr",       instr,       32'hFFFF_FEFF);
    nxt(); #1;
    chk("s3_c8_instr_pc", instr_pc, 32'h104);

    // Redirect coinciding with a response and a decode transfer, unaligned target
    lat = 2;
    do_reset();
    nxt();
    nxt(); #1;
    chk("s4_c2_instr_valid", instr_valid, 32'd0);
    nxt(); #1;
    chk("s4_c3_instr_valid", instr_valid, 32'd1);
    chk("s4_c3_instr_pc",    instr_pc,    32'h0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h203;
    #1;
    chk("s4_redir_req_valid", imem_req_valid, 32'd0);
    nxt();
    redirect_valid = 1'b0;
    #1;
    chk("s4_c4_instr_valid", instr_valid,    32'd0);
    chk("s4_c4_drop_cnt",    dut.drop_cnt_q, 32'd1);
    chk("s4_c4_req_valid",   imem_req_valid, 32'd1);
    chk("s4_c4_addr",        imem_req_addr,  32'h200);
    nxt(); #1;
    chk("s4_c5_instr_valid", instr_valid, 32'd0);
    nxt(); #1;
    chk("s4_c6_instr_valid", instr_valid, 32'd0);
    nxt(); #1;
    chk("s4_c7_instr_valid", instr_valid, 32'd1);
    chk("s4_c7_instr_pc",    instr_pc,    32'h200);
    chk("s4_c7_instr",       instr,       32'hFFFF_FDFF);

    // Redirect to the top word: fetch address wraps to zero
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    nxt();
    redirect_valid = 1'b0;
    #1;
    chk("s5_c8_addr",     imem_req_addr,  32'hFFFF_FFFC);
    chk("s5_c8_drop_cnt", dut.drop_cnt_q, 32'd1);
    nxt(); #1;
    chk("s5_c9_addr",        imem_req_addr, 32'h0);
    chk("s5_c9_instr_valid", instr_valid,   32'd0);
    nxt(); #1;
    chk("s5_c10_addr", imem_req_addr, 32'h4);
    nxt(); #1;
    chk("s5_c11_instr_pc", instr_pc, 32'hFFFF_FFFC);
    chk("s5_c11_instr",    instr,    32'h0000_0003);
    nxt(); #1;
    chk("s5_c12_instr_pc", instr_pc, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
